// File: rtl/des_spi_frontend.sv
// SPI-slave front end for the fixed-key DES core: oversamples a mode-0 SPI link,
// launches one encryption per accepted 64-bit frame and returns the ciphertext on MISO.
module des_spi_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [63:0] pt,
  output logic        start,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic [63:0] ct,
  output logic        ct_new,
  output logic        frame_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  // Idle bus levels, packed as {mosi, cs_n, sck}.
  localparam logic [2:0] SYNC_IDLE = 3'b010;
  localparam logic [6:0] BIT_CNT_MAX = 7'd127;
  localparam logic [6:0] FRAME_BITS  = 7'd64;

  logic [2:0]  sync_q [SYNC_STAGES];
  logic        sck_s, cs_n_s, mosi_s;
  logic        sck_prev, cs_n_prev;
  logic        sck_rise, sck_fall, cs_fall, cs_rise;

  logic [1:0]  state;
  logic        capture;
  logic [63:0] rx_sr;
  logic [6:0]  bit_cnt;
  logic [63:0] tx_sr;
  logic [63:0] tx_next;
  logic [63:0] ct_buf;

  // ---------------------------------------------------------------------------
  // Pin synchronizers and edge history
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous, so every flop tests rst_n inside the clocked
  // block only; rst_n never appears in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
      sck_prev  <= 1'b0;
      cs_n_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q[0] <= {spi_mosi, spi_cs_n, spi_sck};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sck_prev  <= sck_s;
      cs_n_prev <= cs_n_s;
    end
  end

  assign {mosi_s, cs_n_s, sck_s} = sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev & ~cs_n_s;
  assign sck_fall = ~sck_s & sck_prev & ~cs_n_s;
  assign cs_fall  = ~cs_n_s & cs_n_prev;
  assign cs_rise  = cs_n_s & ~cs_n_prev;

  // ---------------------------------------------------------------------------
  // Receive shift register and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sr   <= '0;
      bit_cnt <= '0;
    end else if (cs_fall) begin
      bit_cnt <= '0;
    end else if (sck_rise) begin
      rx_sr <= {rx_sr[62:0], mosi_s};
      if (bit_cnt != BIT_CNT_MAX) bit_cnt <= bit_cnt + 7'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit path and ciphertext buffer
  // ---------------------------------------------------------------------------
  assign capture = (state == S_CAPTURE);

  // A capture coinciding with the frame-start load forwards the fresh result
  // straight into the shifter so the master reads the newest ciphertext.
  always_comb begin
    // NOTE: assigning a default first means every path writes tx_next, so no
    // latch is inferred.
    tx_next = tx_sr;
    if (cs_fall)       tx_next = capture ? ct : ct_buf;
    else if (sck_fall) tx_next = {tx_sr[62:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr    <= '0;
      spi_miso <= 1'b0;
      ct_buf   <= '0;
      ct_new   <= 1'b0;
    end else begin
      tx_sr    <= tx_next;
      spi_miso <= cs_n_s ? 1'b0 : tx_next[63];
      if (capture) begin
        ct_buf <= ct;
        ct_new <= ~cs_fall;
      end else if (cs_fall) begin
        ct_new <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame acceptance / core handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pt        <= '0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_rise) begin
            if (bit_cnt == FRAME_BITS && !core_busy) begin
              pt    <= rx_sr;
              state <= S_START;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        S_START: state <= S_WAIT;
        // core_busy lags start by a cycle, so only core_done marks completion.
        S_WAIT: if (core_done) state <= S_CAPTURE;
        S_CAPTURE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (cs_rise && state != S_IDLE) frame_err <= 1'b1;
    end
  end

  assign start = (state == S_START);

endmodule

// File: tb/tb_des_spi_frontend.sv
// Bench for des_spi_frontend: SPI master tasks, behavioural DES-core stand-in and
// queue-based scoreboards for start/pt and MISO readback.
module tb_des_spi_frontend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso;
  logic [63:0] pt;
  logic        start;
  logic        core_busy, core_done;
  logic [63:0] ct;
  logic        ct_new, frame_err;

  des_spi_frontend #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .pt(pt), .start(start), .core_busy(core_busy), .core_done(core_done), .ct(ct),
    .ct_new(ct_new), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] NOM_PT = 64'h0123456789ABCDEF;
  localparam logic [63:0] NOM_CT = 64'h85E813540F0AB405;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_pt_q[$];
  logic [63:0] exp_rd_q[$];
  logic [63:0] got_rd_q[$];

  logic [63:0] exp_ct_buf = '0;   // what the DUT's ciphertext buffer should hold
  int start_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in for the DES core: the nominal vector from the reference, any other
  // plaintext mapped through a fixed bijective scramble.
  function automatic logic [63:0] model_enc(input logic [63:0] p);
    if (p == NOM_PT) return NOM_CT;
    return {p[31:0], p[63:32]} ^ 64'hC3A5_5A3C_0F1E_2D4B;
  endfunction

  // ---------------------------------------------------------------------------
  // Core model: done pulses core_lat cycles after start, ignores frontend reset
  // ---------------------------------------------------------------------------
  int core_lat = 17;
  int core_cd = 0;
  logic [63:0] core_pt;

  initial begin
    core_done = 1'b0;
    core_busy = 1'b0;
    ct = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (core_cd > 0) begin
        core_cd--;
        if (core_cd == 0) begin
          core_done = 1'b1;
          core_busy = 1'b0;
          ct = model_enc(core_pt);
        end
      end else if (start) begin
        core_pt = pt;
        core_cd = core_lat;
        core_busy = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int done_cyc = -100;
  logic start_prev = 1'b0;
  logic ct_new_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (core_done) done_cyc = cyc;
      if (ct_new && !ct_new_prev) check("ct_new_latency", 64'(cyc - done_cyc), 64'd2);
      if (start) begin
        start_cnt++;
        check("start_width", {63'd0, start_prev}, 64'd0);
        if (exp_pt_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_start: pt=%h with no accepted frame outstanding", pt);
        end else begin
          check("start_pt", pt, exp_pt_q.pop_front());
        end
      end
      start_prev = start;
      ct_new_prev = ct_new;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (got_rd_q.size() > 0) begin
        if (exp_rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL readback_unexpected: got %h with no expectation", got_rd_q.pop_front());
        end else begin
          check("miso_readback", got_rd_q.pop_front(), exp_rd_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SPI master (mode 0, sck = clk/8); drives on negedge, samples MISO before rise
  // ---------------------------------------------------------------------------
  task automatic spi_frame(input int nbits, input logic [127:0] data, input bit cs_low,
                           output logic [63:0] rd, output logic ct_new_end);
    if (!cs_low) begin
      @(negedge clk);
      spi_cs_n = 1'b0;
    end
    rd = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = data[i];
      repeat (4) @(negedge clk);
      rd = {rd[62:0], spi_miso};
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    ct_new_end = ct_new;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // A 64-bit frame the DUT should accept; readback is the current buffer.
  task automatic send_accepted(input logic [63:0] p, output logic ct_new_end);
    logic [63:0] rd;
    exp_pt_q.push_back(p);
    exp_rd_q.push_back(exp_ct_buf);
    spi_frame(64, {64'd0, p}, 1'b0, rd, ct_new_end);
    got_rd_q.push_back(rd);
  endtask

  task automatic wait_ct_new(input int budget, input string name);
    int n = 0;
    while (ct_new !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, ct_new}, 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] p_a, p_b, p_c, rd;
    logic        cne;
    int          n, start_base;

    rst_n = 1'b0;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", {63'd0, spi_miso}, 64'd0);
    check("rst_start", {63'd0, start}, 64'd0);
    check("rst_ct_new", {63'd0, ct_new}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    check("rst_pt", pt, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal encryption, then a follow-up frame that reads the result back.
    send_accepted(NOM_PT, cne);
    wait_ct_new(200, "nom_ct_new");
    exp_ct_buf = model_enc(NOM_PT);
    check("nom_pt", pt, NOM_PT);
    p_a = rnd64();
    send_accepted(p_a, cne);
    check("nom_readback_clears_ct_new", {63'd0, cne}, 64'd0);
    wait_ct_new(200, "nom2_ct_new");
    exp_ct_buf = model_enc(p_a);
    check("nom_frame_err", {63'd0, frame_err}, 64'd0);

    // Frame start strobe lands in the capture cycle.
    p_a = rnd64();
    send_accepted(p_a, cne);
    n = 0;
    while (core_cd != 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sim_align", 64'(core_cd), 64'd1);
    spi_cs_n = 1'b0;
    exp_ct_buf = model_enc(p_a);
    p_b = rnd64();
    exp_pt_q.push_back(p_b);
    exp_rd_q.push_back(exp_ct_buf);
    spi_frame(64, {64'd0, p_b}, 1'b1, rd, cne);
    got_rd_q.push_back(rd);
    check("sim_ct_new_zero", {63'd0, cne}, 64'd0);
    wait_ct_new(200, "sim_next_ct_new");
    exp_ct_buf = model_enc(p_b);

    // A second valid frame completes while the core is still working.
    core_lat = 1500;
    p_a = rnd64();
    send_accepted(p_a, cne);
    check("wait_err_before", {63'd0, frame_err}, 64'd0);
    p_b = rnd64();
    exp_rd_q.push_back(exp_ct_buf);
    spi_frame(64, {64'd0, p_b}, 1'b0, rd, cne);
    got_rd_q.push_back(rd);
    check("wait_frame_err", {63'd0, frame_err}, 64'd1);
    check("wait_pt_kept", pt, p_a);
    wait_ct_new(2000, "wait_first_captured");
    exp_ct_buf = model_enc(p_a);

    // Reset while waiting on the core; the late core_done must be ignored.
    core_lat = 60;
    p_c = rnd64();
    send_accepted(p_c, cne);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_miso", {63'd0, spi_miso}, 64'd0);
    check("midrst_start", {63'd0, start}, 64'd0);
    check("midrst_ct_new", {63'd0, ct_new}, 64'd0);
    check("midrst_frame_err", {63'd0, frame_err}, 64'd0);
    check("midrst_pt", pt, 64'd0);
    rst_n = 1'b1;
    exp_ct_buf = '0;
    n = 0;
    while (core_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst_core_done_seen", {63'd0, core_done}, 64'd1);
    repeat (5) @(negedge clk);
    check("midrst_no_capture", {63'd0, ct_new}, 64'd0);

    // Short and long frames are rejected.
    check("short_err_before", {63'd0, frame_err}, 64'd0);
    spi_frame(63, {64'd0, rnd64()}, 1'b0, rd, cne);
    check("short63_err", {63'd0, frame_err}, 64'd1);
    check("short63_pt", pt, 64'd0);
    spi_frame(65, {63'd0, 1'b1, rnd64()}, 1'b0, rd, cne);
    check("long65_err", {63'd0, frame_err}, 64'd1);
    check("long65_pt", pt, 64'd0);

    // Back-to-back frames from a clean reset.
    pulse_reset();
    core_lat = 17;
    repeat (2) @(negedge clk);
    start_base = start_cnt;
    for (int k = 0; k < 3; k++) begin
      p_a = rnd64();
      send_accepted(p_a, cne);
      wait_ct_new(200, "b2b_ct_new");
      exp_ct_buf = model_enc(p_a);
    end
    check("b2b_starts", 64'(start_cnt - start_base), 64'd3);
    check("b2b_frame_err", {63'd0, frame_err}, 64'd0);

    repeat (10) @(negedge clk);
    check("pt_queue_drained", 64'(exp_pt_q.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
